glcd_frame_sequencer: RTL and testbench

Upstream feeder for the KS0108-style 128x64 graphic LCD bus driver. It owns the panel's power-up command sequence and streams a 1024-byte monochrome framebuffer as ordered byte-write requests: page, half-panel and column order, with page/Y address commands inserted. The bus driver downstream accepts one request at a time over a valid/ready handshake and generates the E/RS/RW pin timing. The sequencer never touches LCD pins directly.

---
 rtl/glcd_frame_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_glcd_frame_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/glcd_frame_sequencer.sv
// Power-up command sequencer and framebuffer streamer for a KS0108-style 128x64 LCD.
// Emits ordered command/data write requests to a downstream bus driver over valid/ready.
module glcd_frame_sequencer #(
    parameter int unsigned AUTO_REFRESH = 0,
    parameter int unsigned START_LINE   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_req,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic       wr_rs,
    output logic       wr_cs1,
    output logic       wr_cs2,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned PAGE_W = 3;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;

    localparam logic [PAGE_W-1:0] LAST_PAGE = '1;
    localparam logic [COL_W-1:0]  LAST_COL  = '1;

    localparam logic [DATA_W-1:0] CMD_DISP_ON = 8'h3F;
    localparam logic [DATA_W-1:0] CMD_LINE    = 8'hC0 | {2'b00, 6'(START_LINE)};
    localparam logic [DATA_W-1:0] CMD_PAGE    = 8'hB8;
    localparam logic [DATA_W-1:0] CMD_Y0      = 8'h40;

    typedef enum logic [2:0] {
        INIT_ON,
        INIT_LINE,
        IDLE,
        PAGE_CMD,
        Y_CMD,
        FETCH,
        LOAD,
        SEND
    } state_t;

    typedef struct packed {
        logic              rs;
        logic              cs1;
        logic              cs2;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    state_t              state_q, state_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic                half_q, half_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                pending_q, pending_d;
    wr_req_t             req_q, req_d;
    logic                valid_d;
    logic                busy_d;
    logic                done_d;

    logic                accept_c;
    logic                last_c;
    logic                want_c;
    logic                start_c;

    assign accept_c = wr_valid && wr_ready;
    assign last_c   = (page_q == LAST_PAGE) && half_q && (col_q == LAST_COL);
    assign want_c   = pending_q || refresh_req;

    // Counters concatenate directly into page*128 + half*64 + column.
    assign fb_addr  = ADDR_W'({page_q, half_q, col_q});

    assign wr_rs    = req_q.rs;
    assign wr_cs1   = req_q.cs1;
    assign wr_cs2   = req_q.cs2;
    assign wr_data  = req_q.data;

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT_ON;
            page_q     <= '0;
            half_q     <= 1'b0;
            col_q      <= '0;
            pending_q  <= 1'b0;
            req_q      <= '0;
            wr_valid   <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            half_q     <= half_d;
            col_q      <= col_d;
            pending_q  <= pending_d;
            req_q      <= req_d;
            wr_valid   <= valid_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

    // Next-state, counter advance and pending-request bookkeeping.
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        half_d    = half_q;
        col_d     = col_q;
        pending_d = pending_q || (refresh_req && (state_q != IDLE));
        done_d    = 1'b0;
        start_c   = 1'b0;

        unique case (state_q)
            INIT_ON: begin
                if (accept_c) state_d = INIT_LINE;
            end
            INIT_LINE: begin
                if (accept_c) state_d = IDLE;
            end
            IDLE: begin
                if (want_c) begin
                    start_c = 1'b1;
                    state_d = PAGE_CMD;
                end
            end
            PAGE_CMD: begin
                if (accept_c) state_d = Y_CMD;
            end
            Y_CMD: begin
                if (accept_c) state_d = FETCH;
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                state_d = SEND;
            end
            SEND: begin
                if (accept_c) begin
                    {page_d, half_d, col_d} = {page_q, half_q, col_q} + ADDR_W'(1);
                    if (last_c) begin
                        done_d = 1'b1;
                        if ((AUTO_REFRESH != 0) || want_c) begin
                            start_c = 1'b1;
                            state_d = PAGE_CMD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (col_q == LAST_COL) begin
                        state_d = PAGE_CMD;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = INIT_ON;
            end
        endcase

        if (start_c) begin
            page_d    = '0;
            half_d    = 1'b0;
            col_d     = '0;
            pending_d = 1'b0;
        end
    end

    // Request payload decoded from the state being entered, so it is valid on entry.
    always_comb begin
        req_d       = '0;
        req_d.data  = req_q.data;
        valid_d     = 1'b0;
        busy_d      = (state_d != IDLE);

        unique case (state_d)
            INIT_ON: begin
                valid_d    = 1'b1;
                req_d.cs1  = 1'b1;
                req_d.cs2  = 1'b1;
                req_d.data = CMD_DISP_ON;
            end
            INIT_LINE: begin
                valid_d    = 1'b1;
                req_d.cs1  = 1'b1;
                req_d.cs2  = 1'b1;
                req_d.data = CMD_LINE;
            end
            PAGE_CMD: begin
                valid_d    = 1'b1;
                req_d.cs1  = !half_d;
                req_d.cs2  = half_d;
                req_d.data = CMD_PAGE | {5'b00000, page_d};
            end
            Y_CMD: begin
                valid_d    = 1'b1;
                req_d.cs1  = !half_d;
                req_d.cs2  = half_d;
                req_d.data = CMD_Y0;
            end
            FETCH, LOAD: begin
                req_d.cs1  = !half_d;
                req_d.cs2  = half_d;
            end
            SEND: begin
                valid_d    = 1'b1;
                req_d.rs   = 1'b1;
                req_d.cs1  = !half_d;
                req_d.cs2  = half_d;
                // RAM output is valid in LOAD; later SEND cycles hold the captured byte.
                if (state_q == LOAD) req_d.data = fb_data;
            end
            default: begin
                valid_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_glcd_frame_sequencer.sv
// Directed/randomized bench for glcd_frame_sequencer: the expected request stream
// is generated arithmetically from page/half/column order and compared per accept.
module tb_glcd_frame_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b;
    logic       refresh_req;
    logic       wr_ready;
    logic       sel;

    logic [9:0] fb_addr_a, fb_addr_b;
    logic [7:0] fb_data_a, fb_data_b;
    logic       wr_valid_a, wr_rs_a, wr_cs1_a, wr_cs2_a, busy_a, frame_done_a;
    logic       wr_valid_b, wr_rs_b, wr_cs1_b, wr_cs2_b, busy_b, frame_done_b;
    logic [7:0] wr_data_a, wr_data_b;

    logic [7:0] fb [1024];

    always @(posedge clk) begin
        fb_data_a <= fb[fb_addr_a];
        fb_data_b <= fb[fb_addr_b];
    end

    glcd_frame_sequencer dut_a (
        .clk(clk), .reset(reset_a), .refresh_req(refresh_req),
        .fb_addr(fb_addr_a), .fb_data(fb_data_a),
        .wr_valid(wr_valid_a), .wr_ready(wr_ready), .wr_rs(wr_rs_a),
        .wr_cs1(wr_cs1_a), .wr_cs2(wr_cs2_a), .wr_data(wr_data_a),
        .busy(busy_a), .frame_done(frame_done_a)
    );

    glcd_frame_sequencer #(.AUTO_REFRESH(1), .START_LINE(13)) dut_b (
        .clk(clk), .reset(reset_b), .refresh_req(refresh_req),
        .fb_addr(fb_addr_b), .fb_data(fb_data_b),
        .wr_valid(wr_valid_b), .wr_ready(wr_ready), .wr_rs(wr_rs_b),
        .wr_cs1(wr_cs1_b), .wr_cs2(wr_cs2_b), .wr_data(wr_data_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    logic       o_valid, o_rs, o_cs1, o_cs2, o_busy, o_done;
    logic [7:0] o_data;
    logic [9:0] o_addr;
    assign o_valid = sel ? wr_valid_b   : wr_valid_a;
    assign o_rs    = sel ? wr_rs_b      : wr_rs_a;
    assign o_cs1   = sel ? wr_cs1_b     : wr_cs1_a;
    assign o_cs2   = sel ? wr_cs2_b     : wr_cs2_a;
    assign o_data  = sel ? wr_data_b    : wr_data_a;
    assign o_busy  = sel ? busy_b       : busy_a;
    assign o_done  = sel ? frame_done_b : frame_done_a;
    assign o_addr  = sel ? fb_addr_b    : fb_addr_a;

    typedef struct {
        logic       rs;
        logic       cs1;
        logic       cs2;
        logic [7:0] data;
        int         gap;
        bit         last;
    } req_t;

    req_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_req(input logic rs, input logic cs1, input logic cs2,
                                     input logic [7:0] d, input int gap, input bit last);
        req_t r;
        r.rs = rs; r.cs1 = cs1; r.cs2 = cs2; r.data = d; r.gap = gap; r.last = last;
        exp_q.push_back(r);
    endfunction

    function automatic void push_init(input logic [5:0] sl);
        push_req(1'b0, 1'b1, 1'b1, 8'h3F, 1, 1'b0);
        push_req(1'b0, 1'b1, 1'b1, 8'hC0 | {2'b00, sl}, 1, 1'b0);
    endfunction

    // One frame: 16 blocks of {page cmd, Y cmd, 64 data}; gap = cycles since previous accept.
    function automatic void push_frame(input int first_gap);
        for (int k = 0; k < 1056; k++) begin
            int         blk, j, p, h;
            logic [7:0] pg;
            blk = k / 66;
            j   = k % 66;
            p   = blk / 2;
            h   = blk % 2;
            pg  = 8'(p);
            if (j == 0)
                push_req(1'b0, h == 0, h == 1, 8'hB8 | pg, (k == 0) ? first_gap : 1, 1'b0);
            else if (j == 1)
                push_req(1'b0, h == 0, h == 1, 8'h40, 1, 1'b0);
            else
                push_req(1'b1, h == 0, h == 1, fb[10'(p * 128 + h * 64 + j - 2)], 3, k == 1055);
        end
    endfunction

    // Drive wr_ready, compare each accepted request against the head of exp_q.
    task automatic consume(input int stall_pct, input int max_acc, input int tail,
                           input int pulse_at, input bit auto_mode);
        int          cyc, last_cyc, acc, budget, pulses, done_seen, done_exp;
        bit          exp_done, prev_stall;
        logic [11:0] prev_pl;
        req_t        e;
        cyc = 0; last_cyc = 0; acc = 0; pulses = 0; done_seen = 0; done_exp = 0;
        exp_done = 1'b0; prev_stall = 1'b0; prev_pl = '0;
        budget = 20 * exp_q.size() + 50;
        while (exp_q.size() != 0 && acc != max_acc) begin
            @(negedge clk);
            cyc++;
            if (pulse_at >= 0 && acc >= pulse_at && pulses < 6) begin
                refresh_req = (pulses % 2 == 0);
                pulses++;
            end else begin
                refresh_req = 1'b0;
            end
            if (o_done === 1'b1) done_seen++;
            check("frame_done", 32'(o_done), 32'(exp_done));
            exp_done = 1'b0;
            if (auto_mode) check("busy_hold", 32'(o_busy), 32'd1);
            if (prev_stall) check("stall_hold", 32'({o_valid, o_rs, o_cs1, o_cs2, o_data}), 32'(prev_pl));
            wr_ready = ($urandom_range(99) >= 32'(stall_pct));
            if (o_valid === 1'b1 && wr_ready) begin
                e = exp_q.pop_front();
                acc++;
                check("req_payload", 32'({o_rs, o_cs1, o_cs2, o_data}), 32'({e.rs, e.cs1, e.cs2, e.data}));
                if (stall_pct == 0 && e.gap > 0) check("req_gap", 32'(cyc - last_cyc), 32'(e.gap));
                last_cyc = cyc;
                exp_done = e.last;
                if (e.last) done_exp++;
            end
            prev_stall = (o_valid === 1'b1) && !wr_ready;
            prev_pl    = {o_valid, o_rs, o_cs1, o_cs2, o_data};
            if (cyc > budget) begin
                check("timeout_accepts", 32'(acc), 32'(acc + exp_q.size()));
                exp_q.delete();
            end
        end
        for (int t = 0; t < tail; t++) begin
            @(negedge clk);
            refresh_req = 1'b0;
            wr_ready    = 1'b1;
            if (o_done === 1'b1) done_seen++;
            check("frame_done", 32'(o_done), 32'(exp_done));
            exp_done = 1'b0;
            check("tail_valid", 32'(o_valid), 32'(auto_mode));
        end
        if (max_acc < 0) check("done_count", 32'(done_seen), 32'(done_exp));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_rs_cs"}, 32'({o_rs, o_cs1, o_cs2}), 32'd0);
        check({tag, "_data"},  32'(o_data), 32'd0);
        check({tag, "_addr"},  32'(o_addr), 32'd0);
        check({tag, "_done"},  32'(o_done), 32'd0);
        check({tag, "_busy"},  32'(o_busy), 32'd1);
    endtask

    initial begin
        sel = 1'b0; reset_a = 1'b1; reset_b = 1'b1;
        refresh_req = 1'b0; wr_ready = 1'b0;
        for (int a = 0; a < 1024; a++) fb[a] = 8'(a);

        // Reset values, then the two init commands and idle.
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_a = 1'b0;
        push_init(6'd0);
        consume(0, -1, 2, -1, 1'b0);
        check("idle_busy", 32'(o_busy), 32'd0);

        // Full frame with an address-pattern framebuffer, no stalls.
        refresh_req = 1'b1;
        push_frame(1);
        consume(0, -1, 4, -1, 1'b0);
        check("idle_busy_f1", 32'(o_busy), 32'd0);

        // Random framebuffer with 50% ready stalls.
        for (int a = 0; a < 1024; a++) fb[a] = 8'($urandom);
        refresh_req = 1'b1;
        push_frame(1);
        consume(50, -1, 4, -1, 1'b0);

        // Three refresh pulses mid-frame merge into exactly one extra frame.
        refresh_req = 1'b1;
        push_frame(1);
        push_frame(1);
        consume(0, -1, 20, 300, 1'b0);
        check("idle_busy_merge", 32'(o_busy), 32'd0);

        // Reset while fetching page 3, column 20.
        refresh_req = 1'b1;
        push_frame(1);
        consume(0, 418, 0, -1, 1'b0);
        @(negedge clk);
        check("mid_addr", 32'(o_addr), 32'd404);
        reset_a = 1'b1;
        #1;
        check_reset_vals("midreset");
        exp_q.delete();
        @(negedge clk);
        reset_a = 1'b0;
        push_init(6'd0);
        consume(0, -1, 2, -1, 1'b0);

        // Auto-refresh instance: back-to-back frames, busy never drops.
        sel = 1'b1;
        @(negedge clk);
        check_reset_vals("auto_reset");
        reset_b = 1'b0;
        push_init(6'd13);
        consume(0, -1, 2, -1, 1'b0);
        refresh_req = 1'b1;
        push_frame(1);
        push_frame(1);
        consume(0, -1, 1, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
